// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequencer and the team ALU it drives.
package fib_pkg;

  localparam int unsigned FIB_WIDTH = 4;
  localparam int unsigned FIB_NW    = 4;

  localparam logic [1:0] ALU_OP_ADD = 2'd0;
  localparam logic [1:0] ALU_OP_SUB = 2'd1;
  localparam logic [1:0] ALU_OP_AND = 2'd2;
  localparam logic [1:0] ALU_OP_OR  = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fib_state_e;

endpackage

// File: rtl/fib_seq_ctrl_alu.sv
// Team shared combinational ALU: add/sub/and/or with carry, overflow and zero flags.
module alu
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             cf,
  output logic             of,
  output logic             zf
);

  logic [WIDTH:0] ext;

  always_comb begin
    ext = '0;
    of  = 1'b0;
    case (op)
      ALU_OP_ADD: ext = {1'b0, a} + {1'b0, b};
      ALU_OP_SUB: ext = {1'b0, a} - {1'b0, b};
      ALU_OP_AND: ext = {1'b0, a & b};
      ALU_OP_OR:  ext = {1'b0, a | b};
      default:    ext = '0;
    endcase
    y  = ext[WIDTH-1:0];
    cf = ext[WIDTH];
    zf = (y == '0);
    // Signed overflow: add with equal operand signs, sub with differing signs.
    if (op == ALU_OP_ADD)
      of = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
    else if (op == ALU_OP_SUB)
      of = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/fib_seq_ctrl.sv
// Host-controlled, abortable F(n) sequencer stepping the shared ALU once per cycle.
module fib_seq_ctrl
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH,
  parameter int unsigned NW    = FIB_NW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NW-1:0]    n,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic [NW-1:0]    step_cnt
);

  fib_state_e       state_q, state_d;
  logic [NW-1:0]    n_lat_q, n_lat_d;
  logic [NW-1:0]    step_q, step_d;
  logic [WIDTH-1:0] fn_q, fn_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] alu_y;
  logic             alu_cf;
  logic             alu_of_unused;
  logic             alu_zf_unused;

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a  (prev_q),
    .b  (fn_q),
    .op (ALU_OP_ADD),
    .y  (alu_y),
    .cf (alu_cf),
    .of (alu_of_unused),
    .zf (alu_zf_unused)
  );

  always_comb begin
    state_d  = state_q;
    n_lat_d  = n_lat_q;
    step_d   = step_q;
    fn_d     = fn_q;
    prev_d   = prev_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_lat_d = n;
          fn_d    = '0;
          prev_d  = WIDTH'(1);
          step_d  = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Abort wins over both the final step and a normal step.
        if (abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (step_q == n_lat_q) begin
          result_d = fn_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          prev_d = fn_q;
          fn_d   = alu_y;
          step_d = step_q + NW'(1);
          ovf_d  = ovf_q | alu_cf;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_lat_q  <= '0;
      step_q   <= '0;
      fn_q     <= '0;
      prev_q   <= WIDTH'(1);
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_lat_q  <= n_lat_d;
      step_q   <= step_d;
      fn_q     <= fn_d;
      prev_q   <= prev_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign ovf      = ovf_q;
  assign step_cnt = step_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Scoreboard bench for fib_seq_ctrl: random and directed runs against an arithmetic Fibonacci model.
module tb_fib_seq_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NW    = 4;
  localparam longint      MOD   = longint'(1) << WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [NW-1:0]    n;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic [NW-1:0]    step_cnt;

  fib_seq_ctrl #(
    .WIDTH (WIDTH),
    .NW    (NW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n        (n),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .ovf      (ovf),
    .step_cnt (step_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     nv;
    longint res;
    longint ovf;
    longint acc;
  } exp_t;

  exp_t   sb[$];
  int     checks   = 0;
  int     failures = 0;
  longint last_res = 0;
  bit     done_prev = 1'b0;

  function automatic longint fib(input int k);
    longint a = 0;
    longint b = 1;
    longint t;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (done_prev) chk("done_one_cycle", done, 0);
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("ovf", ovf, e.ovf);
        chk("step_cnt", step_cnt, e.nv);
        chk("latency", cyc - e.acc, e.nv + 1);
        chk("busy_at_done", busy, 0);
      end
    end
    done_prev = done;
  end

  // Called at a negedge; returns just after the accepting edge.
  task automatic issue(input int nv);
    start = 1'b1;
    n     = NW'(nv);
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back('{nv, fib(nv) % MOD, (fib(nv) >= MOD) ? 1 : 0, cyc});
  endtask

  // Returns at the negedge where done is high.
  task automatic wait_done(output int busy_cyc);
    busy_cyc = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (done) return;
      if (busy) busy_cyc++;
    end
    checks++;
    failures++;
    $display("FAIL done_timeout actual=0 expected=1 (t=%0t)", $time);
  endtask

  task automatic wait_step(input int k);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (step_cnt == NW'(k)) return;
    end
    checks++;
    failures++;
    $display("FAIL step_timeout actual=%0d expected=%0d", step_cnt, k);
  endtask

  task automatic abort_run(input int k);
    exp_t dropped;
    wait_step(k);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    dropped = sb.pop_back();
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, last_res);
    chk("abort_step_cnt", step_cnt, k);
    chk("abort_ovf", ovf, (fib(k) >= MOD) ? 1 : 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int bc;
    int d1;
    int nv;
    int k;
    rst = 1'b1; start = 1'b0; abort = 1'b0; n = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_step_cnt", step_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(0); wait_done(bc); chk("busy_cycles_n0", bc, 1); last_res = 0;
    @(negedge clk);
    issue(6); wait_done(bc); chk("busy_cycles_n6", bc, 7); last_res = fib(6) % MOD;
    @(negedge clk);
    issue(8); wait_done(bc); last_res = fib(8) % MOD;
    issue(15); wait_done(bc); last_res = fib(15) % MOD;

    // Start while busy must be ignored.
    @(negedge clk);
    issue(7);
    repeat (2) @(negedge clk);
    start = 1'b1; n = NW'(2);
    @(negedge clk);
    start = 1'b0;
    wait_done(bc); last_res = fib(7) % MOD;

    @(negedge clk);
    issue(10);
    abort_run(4);
    repeat (15) @(negedge clk);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_result", result, last_res);

    abort = 1'b1;
    issue(5);
    abort = 1'b0;
    wait_done(bc); last_res = fib(5) % MOD;

    // Back-to-back: start accepted in the done cycle.
    @(negedge clk);
    issue(1); wait_done(bc); d1 = cyc;
    issue(2); wait_done(bc);
    chk("b2b_done_gap", cyc - d1, 1 + (2 + 1));
    last_res = fib(2) % MOD;

    @(negedge clk);
    issue(12);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    void'(sb.pop_back());
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_step_cnt", step_cnt, 0);
    rst = 1'b0;
    last_res = 0;
    @(negedge clk);

    for (int it = 0; it < 24; it++) begin
      nv = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      issue(nv);
      if (nv >= 3 && $urandom_range(0, 4) == 0) begin
        k = $urandom_range(0, nv - 1);
        abort_run(k);
        @(negedge clk);
      end else begin
        if (nv >= 2 && $urandom_range(0, 2) == 0) begin
          @(negedge clk);
          start = 1'b1; n = NW'($urandom_range(0, 15));
          @(negedge clk);
          start = 1'b0;
        end
        wait_done(bc);
        last_res = fib(nv) % MOD;
      end
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
